// File: rtl/branch_resolve_predict.sv
// branch_resolve_predict: decode-stage branch/jump resolution plus a direct-mapped
// branch target buffer (BTB) with saturating counters, looked up combinationally by fetch.
// Optional build macro: BRANCH_STATS_EN adds saturating branch / mispredict counters.
module branch_resolve_predict #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] fetch_pc,
  output logic             predict_taken,
  output logic [WIDTH-1:0] predict_target,
  input  logic             stall,
  input  logic             dec_valid,
  input  logic [WIDTH-1:0] dec_pc,
  input  logic [WIDTH-1:0] dec_pc_plus_four,
  input  logic             dec_pred_taken,
  input  logic [WIDTH-1:0] dec_pred_target,
  input  logic             blt,
  input  logic             beq,
  input  logic             bgt,
  input  logic             link_reg,
  input  logic             rt_is_zero,
  input  logic             is_r_type,
  input  logic             is_i_type,
  input  logic             is_j_type,
  input  logic [WIDTH-1:0] reg_rs,
  input  logic [WIDTH-1:0] reg_rt,
  input  logic [WIDTH-1:0] branch_addr,
  input  logic [WIDTH-1:0] jump_addr,
  output logic             resolve_valid,
  output logic             mispredict,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             ra_write,
  output logic [WIDTH-1:0] ra_write_value
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  localparam int IDX   = $clog2(DEPTH);
  localparam int TAG_W = WIDTH - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  // BTB storage, one field array per entry component
  logic [DEPTH-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q    [DEPTH];
  logic [WIDTH-1:0]    target_q [DEPTH];
  logic [CTR_BITS-1:0] ctr_q    [DEPTH];

  logic [IDX-1:0]   f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  // Fetch-side lookup sees the table contents from before any same-edge update
  always_comb begin
    f_idx          = fetch_pc[IDX+1:2];
    f_tag          = fetch_pc[WIDTH-1:IDX+2];
    f_hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    predict_taken  = f_hit && ctr_q[f_idx][CTR_BITS-1];
    predict_target = f_hit ? target_q[f_idx] : fetch_pc + WIDTH'(4);
  end

  logic                ctl;
  logic                taken;
  logic                mispredict_c;
  logic [WIDTH-1:0]    rt_eff;
  logic [WIDTH-1:0]    res_target;
  logic [IDX-1:0]      d_idx;
  logic [TAG_W-1:0]    d_tag;
  logic                d_hit;
  logic [CTR_BITS-1:0] ctr_next;

  // Decode-side resolution: condition, target, mispredict and counter step
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    res_target = '0;
    ctl        = dec_valid & ~stall & (blt | beq | bgt);
    rt_eff     = rt_is_zero ? '0 : reg_rt;
    taken      = (blt & (reg_rs < rt_eff)) |
                 (beq & (reg_rs == rt_eff)) |
                 (bgt & (reg_rs > rt_eff));
    if (is_r_type)      res_target = reg_rs;
    else if (is_i_type) res_target = branch_addr;
    else if (is_j_type) res_target = jump_addr;
    mispredict_c = (taken != dec_pred_taken) | (taken & (res_target != dec_pred_target));
    d_idx    = dec_pc[IDX+1:2];
    d_tag    = dec_pc[WIDTH-1:IDX+2];
    d_hit    = valid_q[d_idx] && (tag_q[d_idx] == d_tag);
    ctr_next = ctr_q[d_idx];
    if (taken && ctr_q[d_idx] != CTR_MAX)
      ctr_next = ctr_q[d_idx] + CTR_BITS'(1);
    else if (!taken && ctr_q[d_idx] != '0)
      ctr_next = ctr_q[d_idx] - CTR_BITS'(1);
  end

  // Valid bits and counters: cleared by reset, trained or allocated on resolution
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_WEAK_NT;
    end else if (ctl) begin
      if (d_hit) begin
        ctr_q[d_idx] <= ctr_next;
      end else if (taken) begin
        valid_q[d_idx] <= 1'b1;
        ctr_q[d_idx]   <= CTR_WEAK_T;
      end
    end
  end

  // Tag and target: written on any taken resolution (hit refresh or allocation)
  always_ff @(posedge clock) begin
    // NOTE: tag/target need no reset; valid_q masks their contents until first written.
    if (!reset && ctl && taken) begin
      tag_q[d_idx]    <= d_tag;
      target_q[d_idx] <= res_target;
    end
  end

  // Registered resolution outputs; data fields hold when nothing resolves
  always_ff @(posedge clock) begin
    if (reset) begin
      resolve_valid  <= 1'b0;
      mispredict     <= 1'b0;
      ra_write       <= 1'b0;
      redirect_pc    <= '0;
      ra_write_value <= '0;
    end else begin
      resolve_valid <= ctl;
      mispredict    <= ctl & mispredict_c;
      ra_write      <= ctl & taken & link_reg;
      if (ctl) begin
        redirect_pc    <= taken ? res_target : dec_pc + WIDTH'(4);
        ra_write_value <= dec_pc_plus_four;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating tallies of resolved branches and of mispredictions
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (ctl) begin
      if (stat_branches != '1) stat_branches <= stat_branches + STAT_W'(1);
      if (mispredict_c && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Scoreboard bench for branch_resolve_predict: directed scenarios followed by random
// traffic, all checked against a behavioural BTB / resolution model.
module tb_branch_resolve_predict;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 16;
  localparam int CTR_BITS = 2;
  localparam int STAT_W   = 32;
  localparam int CMAX     = (1 << CTR_BITS) - 1;
  localparam int HALF     = 1 << (CTR_BITS - 1);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] fetch_pc = '0;
  logic             predict_taken;
  logic [WIDTH-1:0] predict_target;
  logic             stall = 1'b0, dec_valid = 1'b0;
  logic [WIDTH-1:0] dec_pc = '0, dec_pc_plus_four = '0, dec_pred_target = '0;
  logic             dec_pred_taken = 1'b0;
  logic             blt = 1'b0, beq = 1'b0, bgt = 1'b0, link_reg = 1'b0, rt_is_zero = 1'b0;
  logic             is_r_type = 1'b0, is_i_type = 1'b0, is_j_type = 1'b0;
  logic [WIDTH-1:0] reg_rs = '0, reg_rt = '0, branch_addr = '0, jump_addr = '0;
  logic             resolve_valid, mispredict, ra_write;
  logic [WIDTH-1:0] redirect_pc, ra_write_value;
`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches, stat_mispredicts;
`endif

  branch_resolve_predict #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CTR_BITS(CTR_BITS), .STAT_W(STAT_W)) dut (
    .clock(clock), .reset(reset), .fetch_pc(fetch_pc),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .stall(stall), .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_pc_plus_four(dec_pc_plus_four),
    .dec_pred_taken(dec_pred_taken), .dec_pred_target(dec_pred_target),
    .blt(blt), .beq(beq), .bgt(bgt), .link_reg(link_reg), .rt_is_zero(rt_is_zero),
    .is_r_type(is_r_type), .is_i_type(is_i_type), .is_j_type(is_j_type),
    .reg_rs(reg_rs), .reg_rt(reg_rt), .branch_addr(branch_addr), .jump_addr(jump_addr),
    .resolve_valid(resolve_valid), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .ra_write(ra_write), .ra_write_value(ra_write_value)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: BTB as plain arrays indexed by (pc/4) mod DEPTH
  bit               m_valid [DEPTH];
  logic [WIDTH-1:0] m_tag   [DEPTH];
  logic [WIDTH-1:0] m_tgt   [DEPTH];
  int               m_ctr   [DEPTH];
  int               st_br = 0, st_mis = 0;
  logic [WIDTH-1:0] hold_red = '0, hold_ra = '0;

  typedef struct {
    logic             mis;
    logic [WIDTH-1:0] red;
    logic             raw;
    logic [WIDTH-1:0] rav;
  } exp_t;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;

  function automatic int m_idx(input logic [WIDTH-1:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic logic [WIDTH-1:0] m_tagof(input logic [WIDTH-1:0] pc);
    return pc / (4 * DEPTH);
  endfunction

  function automatic bit m_hit(input logic [WIDTH-1:0] pc);
    return m_valid[m_idx(pc)] && m_tag[m_idx(pc)] == m_tagof(pc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = HALF - 1;
    end
    st_br = 0; st_mis = 0; hold_red = '0; hold_ra = '0;
    exp_q.delete();
  endtask

  // One clock of stimulus: check fetch prediction, predict resolution, advance model
  task automatic step();
    bit ctl, taken, mis, hit;
    int i;
    logic [WIDTH-1:0] rt, tgt;
    exp_t e;
    #1;
    hit = m_hit(fetch_pc);
    i   = m_idx(fetch_pc);
    check("predict_taken", predict_taken, hit && m_ctr[i] >= HALF);
    check("predict_target", predict_target, hit ? m_tgt[i] : fetch_pc + 4);
    ctl   = dec_valid && !stall && (blt || beq || bgt);
    rt    = rt_is_zero ? 0 : reg_rt;
    taken = (blt && reg_rs < rt) || (beq && reg_rs == rt) || (bgt && reg_rs > rt);
    tgt   = is_r_type ? reg_rs : is_i_type ? branch_addr : is_j_type ? jump_addr : 0;
    mis   = (taken != dec_pred_taken) || (taken && tgt != dec_pred_target);
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else if (ctl) begin
      e.mis = mis; e.red = taken ? tgt : dec_pc + 4; e.raw = taken && link_reg;
      e.rav = dec_pc_plus_four;
      exp_q.push_back(e);
      hold_red = e.red; hold_ra = e.rav;
      st_br++; if (mis) st_mis++;
      i = m_idx(dec_pc);
      if (m_hit(dec_pc)) begin
        if (taken) begin
          m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
          m_tgt[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (taken) begin
        m_valid[i] = 1'b1; m_tag[i] = m_tagof(dec_pc); m_tgt[i] = tgt; m_ctr[i] = HALF;
      end
    end
    @(negedge clock);
  endtask

  task automatic clr_dec();
    dec_valid = 0; stall = 0; blt = 0; beq = 0; bgt = 0; link_reg = 0; rt_is_zero = 0;
    is_r_type = 0; is_i_type = 0; is_j_type = 0; dec_pred_taken = 0; dec_pred_target = 0;
    reg_rs = 0; reg_rt = 0; branch_addr = 0; jump_addr = 0;
  endtask

  task automatic set_br(input logic [WIDTH-1:0] pc, input bit l, input bit e, input bit g,
                        input logic [WIDTH-1:0] rs, input logic [WIDTH-1:0] rtv,
                        input logic [WIDTH-1:0] baddr);
    clr_dec();
    dec_valid = 1; dec_pc = pc; dec_pc_plus_four = pc + 4;
    blt = l; beq = e; bgt = g; reg_rs = rs; reg_rt = rtv; is_i_type = 1; branch_addr = baddr;
  endtask

  // Monitor: every negedge either pops one expected resolution or expects an idle cycle
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("resolve_valid", resolve_valid, 1);
        check("mispredict", mispredict, e.mis);
        check("redirect_pc", redirect_pc, e.red);
        check("ra_write", ra_write, e.raw);
        check("ra_write_value", ra_write_value, e.rav);
      end else begin
        check("idle_resolve_valid", resolve_valid, 0);
        check("idle_mispredict", mispredict, 0);
        check("idle_ra_write", ra_write, 0);
        check("hold_redirect_pc", redirect_pc, hold_red);
        check("hold_ra_value", ra_write_value, hold_ra);
      end
    end
  end

  logic [WIDTH-1:0] pcs [6] = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h2100, 32'h3C};

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset  = 0;
    mon_en = 1;

    // 1: post-reset lookup misses, outputs idle
    fetch_pc = 32'h100; step();

    // 2: beq taken, predicted not-taken -> mispredict to 0x200, then BTB hit
    set_br(32'h100, 0, 1, 0, 5, 5, 32'h200); step();
    clr_dec(); step();

    // 3: three taken then three not-taken on the same branch
    repeat (3) begin set_br(32'h100, 0, 1, 0, 7, 7, 32'h200); step(); end
    repeat (3) begin set_br(32'h100, 0, 1, 0, 7, 8, 32'h200); step(); end
    clr_dec(); step();
    #1 check("t3_final_predict_taken", predict_taken, 0);
    @(negedge clock);

    // 4: jal with correct prediction, link written
    clr_dec(); dec_valid = 1; blt = 1; beq = 1; bgt = 1; is_j_type = 1; link_reg = 1;
    jump_addr = 32'h400; dec_pc = 32'h80; dec_pc_plus_four = 32'h84;
    dec_pred_taken = 1; dec_pred_target = 32'h400; step();
    clr_dec(); step();

    // 5: unsigned blt with rt forced to zero, stalled branch, reset during a branch
    set_br(32'h180, 1, 0, 0, 32'hFFFF_FFFF, 1, 32'h500); rt_is_zero = 1; step();
    set_br(32'h180, 0, 1, 0, 3, 3, 32'h500); stall = 1; fetch_pc = 32'h180; step();
    clr_dec(); step();
    set_br(32'h180, 0, 1, 0, 3, 3, 32'h500); reset = 1; step();
    reset = 0; clr_dec(); fetch_pc = 32'h80; step();
    fetch_pc = 32'h100; step();

    // 6: aliasing entries 0x100 / 0x140 share index 0
    set_br(32'h100, 0, 1, 0, 1, 1, 32'h600); step();
    set_br(32'h140, 0, 0, 1, 9, 2, 32'h700); step();
    clr_dec(); fetch_pc = 32'h100; step();
    fetch_pc = 32'h140; step();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int k;
      clr_dec();
      reset     = ($urandom_range(0, 99) == 0);
      fetch_pc  = pcs[$urandom_range(0, 5)];
      dec_valid = $urandom_range(0, 9) != 0;
      stall     = $urandom_range(0, 7) == 0;
      dec_pc    = pcs[$urandom_range(0, 5)];
      dec_pc_plus_four = dec_pc + 4;
      {blt, beq, bgt} = 3'($urandom_range(0, 7));
      link_reg   = $urandom_range(0, 1) != 0;
      rt_is_zero = $urandom_range(0, 5) == 0;
      reg_rs = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 3));
      reg_rt = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 3));
      branch_addr = 32'($urandom_range(0, 3)) * 32'h40 + 32'h1000;
      jump_addr   = $urandom & 32'hFFFF_FFFC;
      k = $urandom_range(0, 3);
      is_r_type = (k == 0); is_i_type = (k == 1); is_j_type = (k == 2);
      if ($urandom_range(0, 1) != 0) begin
        dec_pred_taken  = m_hit(dec_pc) && m_ctr[m_idx(dec_pc)] >= HALF;
        dec_pred_target = m_hit(dec_pc) ? m_tgt[m_idx(dec_pc)] : dec_pc + 4;
      end else begin
        dec_pred_taken  = $urandom_range(0, 1) != 0;
        dec_pred_target = branch_addr;
      end
      step();
    end
    reset = 0; clr_dec();
    repeat (3) step();
    check("queue_drained", 64'(exp_q.size()), 0);
`ifdef BRANCH_STATS_EN
    check("stat_branches", stat_branches, st_br);
    check("stat_mispredicts", stat_mispredicts, st_mis);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
